// File: rtl/ser2par.sv
// Serial-to-parallel deserializer: packs a programmable number of SW-bit beats
// into a right-justified PW-bit word, with a one-word skid toward the core.
module ser2par #(
    parameter  int PW = 64,
    parameter  int SW = 1,
    localparam int NB = PW / SW,
    localparam int CW = $clog2(NB) + 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [SW-1:0] din,
    input  logic          access_in,
    input  logic [7:0]    datasize,
    input  logic          lsbfirst,
    input  logic          clear,
    input  logic          wait_in,
    output logic [PW-1:0] dout,
    output logic          access_out,
    output logic          wait_out,
    output logic          busy
);

    logic [CW-1:0] count;
    logic [CW-1:0] size;
    logic [CW-1:0] first_size;
    logic [CW-1:0] word_size;
    logic [CW-1:0] count_inc;
    logic          mode;
    logic          word_mode;
    logic          pend;
    logic          valid;
    logic          accept;
    logic          complete;
    logic          consume;
    logic          out_free;
    logic [PW-1:0] shiftreg;
    logic [PW-1:0] base;
    logic [PW-1:0] assembled;

    // Word size and bit order come straight from the inputs on the first beat,
    // and from the latched copies for every later beat of the same word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_size = CW'(datasize);
        if (datasize == 8'd0 || int'(datasize) > NB)
            first_size = CW'(NB);

        accept    = access_in & ~pend & ~clear;
        word_size = (count == '0) ? first_size : size;
        word_mode = (count == '0) ? lsbfirst : mode;
        count_inc = count + CW'(1);
        complete  = accept & (count_inc == word_size);
        consume   = valid & ~wait_in;
        out_free  = ~valid | consume;

        base      = (count == '0) ? '0 : shiftreg;
        assembled = base;
        if (word_mode)
            assembled[count*SW +: SW] = din;
        else
            assembled = (base << SW) | PW'(din);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count    <= '0;
            size     <= '0;
            mode     <= 1'b0;
            pend     <= 1'b0;
            valid    <= 1'b0;
            shiftreg <= '0;
            dout     <= '0;
        end else if (clear) begin
            count <= '0;
            pend  <= 1'b0;
            valid <= 1'b0;
        end else begin
            if (accept) begin
                shiftreg <= assembled;
                count    <= complete ? '0 : count_inc;
                if (count == '0) begin
                    size <= first_size;
                    mode <= lsbfirst;
                end
            end

            // A finished word either goes straight to the output register or
            // parks in shiftreg (pend) until the core frees the output.
            if (complete && out_free) begin
                dout  <= assembled;
                valid <= 1'b1;
            end else if (complete) begin
                pend <= 1'b1;
            end else if (pend && out_free) begin
                dout  <= shiftreg;
                valid <= 1'b1;
                pend  <= 1'b0;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

    assign access_out = valid;
    assign wait_out   = pend;
    assign busy       = (count != '0) | pend;

endmodule
